// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling, LSB first, framing check.
// Define UART_RX_PARITY_EN to add a parity bit, PARITY_ODD and o_parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
    ,
    parameter int unsigned PARITY_ODD = 0
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sample_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 o_parity_err
`endif
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_rx_state_t       r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit;
    logic                 r_parity_err;
    logic                 w_par_bad;

    // Data XOR received parity must equal the selected parity sense.
    assign w_par_bad = ((^r_shift) ^ r_par_bit) != 1'(PARITY_ODD);
`endif

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_rx),
        .o_q    (w_rx_s)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (i_sample_tick) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rx_s) begin
                            r_state    <= START;
                            r_tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (r_tick_cnt == TICK_MID) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_state    <= w_rx_s ? IDLE : DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (r_tick_cnt == TICK_END) begin
                            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (r_tick_cnt == TICK_END) begin
                            r_par_bit  <= w_rx_s;
                            r_tick_cnt <= '0;
                            r_state    <= STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (r_tick_cnt == TICK_END) begin
                            r_rx_data  <= r_shift;
                            r_tick_cnt <= '0;
                            r_state    <= IDLE;
                            if (!w_rx_s) begin
                                r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (w_par_bad) begin
                                r_parity_err <= 1'b1;
`endif
                            end else begin
                                r_rx_valid <= 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, expected results queued, monitor compares.
module tb_uart_rx;

    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_FERR  = 2'd1;
    localparam logic [1:0] K_PERR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       sample_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`else
    logic       parity_err;
    assign parity_err = 1'b0;
`endif

    int total;
    int bad;
    int cyc;
    int pulses;
    int valid_cyc[$];
    exp_t exp_q[$];

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD(0)
`endif
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sample_tick(sample_tick),
        .i_rx         (rx),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_frame_err  (frame_err),
        .o_busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic has_par, input logic par_b);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (16) @(negedge clk);
        end
        if (has_par) begin
            rx = par_b;
            repeat (16) @(negedge clk);
        end
        rx = stop_b;
        repeat (16) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every result pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        logic [1:0] k;
        forever begin
            @(negedge clk);
            if (rst_n && (rx_valid || frame_err || parity_err)) begin
                pulses = pulses + 1;
                chk("exclusive_pulses", 32'(rx_valid + frame_err + parity_err), 32'd1);
                k = rx_valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
                if (rx_valid) valid_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse_kind", 32'(k), 32'hFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", 32'(k), 32'(e.kind));
                    chk("pulse_data", 32'(rx_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        int p0;
        total = 0;
        bad = 0;
        cyc = 0;
        pulses = 0;
        rst_n = 1'b0;
        sample_tick = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", 32'(rx_data), 32'h0);
        chk("reset_valid", 32'(rx_valid), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        idle(5);

        // Good frame 0x55.
        exp_q.push_back('{kind: K_VALID, data: 8'h55});
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("f55_busy_after", 32'(busy), 32'h0);
        chk("f55_data_held", 32'(rx_data), 32'h55);

        // Short low glitch rejected at mid start bit.
        p0 = pulses;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_high", 32'(busy), 32'h1);
        idle(20);
        chk("glitch_busy_low", 32'(busy), 32'h0);
        chk("glitch_no_pulse", 32'(pulses - p0), 32'h0);

        // Framing error on 0xA3.
        exp_q.push_back('{kind: K_FERR, data: 8'hA3});
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        idle(30);
        chk("fa3_data", 32'(rx_data), 32'hA3);
        chk("fa3_busy_after", 32'(busy), 32'h0);

        // Reset during data bit 4 of 0xFF.
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (16) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("midframe_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data", 32'(rx_data), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_valid", 32'(rx_valid), 32'h0);
        chk("rst_mid_ferr", 32'(frame_err), 32'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        exp_q.push_back('{kind: K_VALID, data: 8'h3C});
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("f3c_data", 32'(rx_data), 32'h3C);

        // Back-to-back 0x00 then 0xFF.
        valid_cyc.delete();
        exp_q.push_back('{kind: K_VALID, data: 8'h00});
        exp_q.push_back('{kind: K_VALID, data: 8'hFF});
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("b2b_pulse_count", 32'(valid_cyc.size()), 32'd2);
        if (valid_cyc.size() == 2)
            chk("b2b_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'd160);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back('{kind: K_PERR, data: 8'h07});
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(20);
        exp_q.push_back('{kind: K_VALID, data: 8'h07});
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(20);
        chk("par_data", 32'(rx_data), 32'h07);
`endif

        idle(10);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
